// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer
// Sequences one DSP48A1 slice through an N-term multiply-accumulate (P = sum A*B).
// It takes a command (term count, clear/continue) and a valid/ready operand stream.
// It drives the slice clock enables, P reset and OPMODE, and tracks the slice pipeline
// so that the result handshake is offered only once P holds the final sum.

module dsp48a1_mac_sequencer #(
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned PIPE_LAT = 3   // legal range 2..8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_clr,
   input  logic             op_valid,
   output logic             op_ready,
   output logic             dsp_ce_ab,
   output logic             dsp_ce_m,
   output logic             dsp_ce_p,
   output logic             dsp_rst_p,
   output logic [7:0]       dsp_opmode,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   // The A/B register stage is the handshake itself, so the tag line covers
   // the remaining M and P stages.
   localparam int unsigned DL_DEPTH = PIPE_LAT - 1;

   localparam logic [7:0] OPMODE_M_ONLY  = 8'h01;  // X=M, Z=0
   localparam logic [7:0] OPMODE_M_PLUS_P = 8'h09; // X=M, Z=P

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_ISSUE,
      S_DRAIN,
      S_RESULT
   } state_t;

   typedef struct packed {
      logic valid;
      logic first;
   } tag_t;

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] remaining;
   logic             first_pend;
   tag_t             dl [DL_DEPTH];
   logic             cmd_hs;
   logic             op_hs;
   logic             upper_busy;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      op_ready  = 1'b0;
      dsp_rst_p = 1'b0;
      res_valid = 1'b0;
      busy      = (state != S_IDLE);
      cmd_hs    = 1'b0;
      op_hs     = 1'b0;
      dsp_ce_ab = 1'b0;

      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            cmd_hs    = cmd_valid;
            if (cmd_valid) begin
               if (cmd_len != '0) begin
                  state_nxt = S_ISSUE;
               end else if (cmd_clr) begin
                  state_nxt = S_CLR;
               end else begin
                  state_nxt = S_RESULT;
               end
            end
         end
         S_CLR: begin
            dsp_rst_p = 1'b1;
            state_nxt = S_RESULT;
         end
         S_ISSUE: begin
            op_ready  = (remaining != '0);
            op_hs     = op_valid & op_ready;
            dsp_ce_ab = op_hs;
            if (op_hs && (remaining == LEN_W'(1))) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave once only the tail stage may still hold a tag: it retires
            // into P this cycle, so P is final in the next one.
            if (!upper_busy) begin
               state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Term counter and first-term flag, loaded by the command handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining  <= '0;
         first_pend <= 1'b0;
      end else if (cmd_hs) begin
         remaining  <= cmd_len;
         first_pend <= cmd_clr;
      end else if (op_hs) begin
         remaining  <= remaining - LEN_W'(1);
         first_pend <= 1'b0;
      end
   end

   // Tag delay line tracking each accepted term through the M and P stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DL_DEPTH; i++) begin
            dl[i] <= '0;
         end
      end else begin
         dl[0] <= {op_hs, op_hs & first_pend};
         for (int unsigned i = 1; i < DL_DEPTH; i++) begin
            dl[i] <= dl[i-1];
         end
      end
   end

   // Occupancy of every delay-line stage except the tail
   always_comb begin
      upper_busy = 1'b0;
      for (int unsigned i = 0; i + 1 < DL_DEPTH; i++) begin
         upper_busy = upper_busy | dl[i].valid;
      end
   end

   // M register enable follows the A/B enable by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dsp_ce_m <= 1'b0;
      end else begin
         dsp_ce_m <= dsp_ce_ab;
      end
   end

   // P enable and OPMODE decoded from the delay-line tail register
   always_comb begin
      dsp_ce_p   = dl[DL_DEPTH-1].valid;
      dsp_opmode = 8'h00;
      if (dl[DL_DEPTH-1].valid) begin
         dsp_opmode = dl[DL_DEPTH-1].first ? OPMODE_M_ONLY : OPMODE_M_PLUS_P;
      end
   end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb_dsp48a1_mac_sequencer
// Scoreboard bench: each accepted operand pushes the expected M/P enable cycles and
// OPMODE; a monitor pops and compares them every cycle.

module tb_dsp48a1_mac_sequencer;

   localparam int unsigned LEN_W    = 8;
   localparam int unsigned PIPE_LAT = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_clr;
   logic             op_valid;
   logic             op_ready;
   logic             dsp_ce_ab;
   logic             dsp_ce_m;
   logic             dsp_ce_p;
   logic             dsp_rst_p;
   logic [7:0]       dsp_opmode;
   logic             res_valid;
   logic             res_ready;
   logic             busy;

   dsp48a1_mac_sequencer #(
      .LEN_W    (LEN_W),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_len    (cmd_len),
      .cmd_clr    (cmd_clr),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .dsp_ce_ab  (dsp_ce_ab),
      .dsp_ce_m   (dsp_ce_m),
      .dsp_ce_p   (dsp_ce_p),
      .dsp_rst_p  (dsp_rst_p),
      .dsp_opmode (dsp_opmode),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  opm;
   } pexp_t;

   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned qm [$];
   pexp_t       qp [$];
   int unsigned rstp_cyc = 32'hFFFF_FFFF;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Per-cycle monitor for the pipelined slice controls
   always @(negedge clk) begin
      logic       em;
      logic       ep;
      logic [7:0] eo;
      if (mon_en) begin
         em = (qm.size() > 0) && (qm[0] == cyc);
         if (em) void'(qm.pop_front());
         ep = (qp.size() > 0) && (qp[0].cyc == cyc);
         eo = 8'h00;
         if (ep) begin
            eo = qp[0].opm;
            void'(qp.pop_front());
         end
         check_eq("ce_m", {31'd0, dsp_ce_m}, {31'd0, em});
         check_eq("ce_p", {31'd0, dsp_ce_p}, {31'd0, ep});
         check_eq("opmode", {24'd0, dsp_opmode}, {24'd0, eo});
         check_eq("rst_p", {31'd0, dsp_rst_p}, {31'd0, (cyc == rstp_cyc)});
      end
   end

   task automatic run_cmd(input int unsigned len, input bit clr, input logic [7:0] pat,
                          input int unsigned hold);
      int unsigned n;
      int unsigned k;
      int unsigned t_last;
      int unsigned t_acc;
      int unsigned t_res;
      bit          is_first;
      pexp_t       e;
      bit          hit;

      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
      cmd_clr   = clr;
      @(negedge clk);
      check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      check_eq("busy_idle", {31'd0, busy}, 32'd0);
      t_acc = cyc;
      if (len == 0 && clr) rstp_cyc = t_acc + 1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;

      n        = 0;
      k        = 0;
      t_last   = 0;
      is_first = clr;
      if (len > 0) begin
         while (n < len && k < 200) begin
            op_valid = pat[k % 8];
            k++;
            @(negedge clk);
            check_eq("op_ready", {31'd0, op_ready}, 32'd1);
            check_eq("ce_ab", {31'd0, dsp_ce_ab}, {31'd0, op_valid});
            check_eq("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            if (op_valid) begin
               qm.push_back(cyc + 1);
               e.cyc = cyc + PIPE_LAT - 1;
               e.opm = is_first ? 8'h01 : 8'h09;
               qp.push_back(e);
               is_first = 1'b0;
               n++;
               t_last = cyc;
            end
            @(posedge clk); #1;
         end
         op_valid = 1'b1;   // keep offering; must be refused after the last term
         t_res = t_last + PIPE_LAT;
      end else begin
         t_res = t_acc + (clr ? 2 : 1);
      end

      hit = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (cyc == t_res) begin
            hit = 1'b1;
            break;
         end
         check_eq("res_early", {31'd0, res_valid}, 32'd0);
         check_eq("op_ready_drain", {31'd0, op_ready}, 32'd0);
         check_eq("ce_ab_drain", {31'd0, dsp_ce_ab}, 32'd0);
         @(posedge clk); #1;
      end
      check_eq("res_reached", {31'd0, hit}, 32'd1);
      check_eq("res_valid", {31'd0, res_valid}, 32'd1);
      check_eq("cmd_ready_res", {31'd0, cmd_ready}, 32'd0);

      for (int unsigned h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_eq("res_hold", {31'd0, res_valid}, 32'd1);
         check_eq("cmd_ready_hold", {31'd0, cmd_ready}, 32'd0);
         check_eq("busy_hold", {31'd0, busy}, 32'd1);
         check_eq("ce_ab_hold", {31'd0, dsp_ce_ab}, 32'd0);
      end

      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
      check_eq("res_valid_hs", {31'd0, res_valid}, 32'd1);
      @(posedge clk); #1;
      res_ready = 1'b0;
      op_valid  = 1'b0;
      @(negedge clk);
      check_eq("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
      check_eq("busy_after", {31'd0, busy}, 32'd0);
      check_eq("res_valid_after", {31'd0, res_valid}, 32'd0);
      check_eq("qp_drained", qp.size(), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_clr   = 1'b0;
      op_valid  = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_op_ready", {31'd0, op_ready}, 32'd0);
      check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_cmd(4, 1'b1, 8'hFF, 0);      // back-to-back terms, clear first
      run_cmd(3, 1'b1, 8'h15, 0);      // operand gaps 1,0,1,0,1
      run_cmd(2, 1'b0, 8'hFF, 0);      // continue onto existing P
      run_cmd(0, 1'b1, 8'hFF, 0);      // clear-only command
      run_cmd(0, 1'b0, 8'hFF, 0);      // empty command, straight to result
      run_cmd(2, 1'b1, 8'hFF, 5);      // consumer stalls in RESULT
      run_cmd(1, 1'b1, 8'hFF, 0);      // single term
      for (int r = 0; r < 3; r++) begin
         run_cmd($urandom_range(1, 12), 1'($urandom_range(0, 1)),
                 8'($urandom) | 8'h01, $urandom_range(0, 3));
      end

      // Reset after two of four accepted terms
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(4);
      cmd_clr   = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      op_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("rst_test_op_ready", {31'd0, op_ready}, 32'd1);
         qm.push_back(cyc + 1);
         qp.push_back('{cyc + PIPE_LAT - 1, (i == 0) ? 8'h01 : 8'h09});
         @(posedge clk); #1;
      end
      rst = 1'b1;
      qm.delete();
      qp.delete();
      @(negedge clk);
      check_eq("midrst_op_ready", {31'd0, op_ready}, 32'd0);
      check_eq("midrst_ce_ab", {31'd0, dsp_ce_ab}, 32'd0);
      check_eq("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_res_valid", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst      = 1'b0;
      op_valid = 1'b0;
      @(negedge clk);
      check_eq("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      run_cmd(1, 1'b1, 8'hFF, 0);

      @(negedge clk);
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
